// File: rtl/wb_queue.sv
// Writeback queue in front of the register file write port: buffers results in a
// small FIFO, drains one registered write per cycle, and reports pending registers.
module wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     drain_en,
   output logic                     wEn,
   output logic [SEL_W-1:0]         write_sel,
   output logic [DATA_W-1:0]        write_data,
   input  logic [SEL_W-1:0]         rs1_sel,
   input  logic [SEL_W-1:0]         rs2_sel,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [SEL_W-1:0]  sel_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [DEPTH-1:0]  entry_valid;
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic              push;
   logic              pop;
   logic              rs1_hit;
   logic              rs2_hit;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign in_ready = !full;

   // Register 0 completes the handshake but is never queued.
   assign push = in_valid && in_ready && (in_sel != '0);
   assign pop  = drain_en && !empty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         entry_valid <= '0;
         wEn         <= 1'b0;
         write_sel   <= '0;
         write_data  <= '0;
      end else begin
         if (push) begin
            tail              <= tail + PW'(1);
            entry_valid[tail] <= 1'b1;
         end
         if (pop) begin
            head              <= head + PW'(1);
            entry_valid[head] <= 1'b0;
            write_sel         <= sel_mem[head];
            write_data        <= data_mem[head];
         end
         wEn <= pop;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload storage has no reset; entry_valid alone decides whether a slot counts.
   always_ff @(posedge clock) begin
      if (push) begin
         sel_mem[tail]  <= in_sel;
         data_mem[tail] <= in_data;
      end
   end

   // NOTE: combinational logic uses blocking assignments, with defaults first so no latch is inferred.
   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (sel_mem[i] == rs1_sel)) rs1_hit = 1'b1;
         if (entry_valid[i] && (sel_mem[i] == rs2_sel)) rs2_hit = 1'b1;
      end
      // The output stage stays busy until the register file has captured it.
      if (wEn && (write_sel == rs1_sel)) rs1_hit = 1'b1;
      if (wEn && (write_sel == rs2_sel)) rs2_hit = 1'b1;
   end

   assign rs1_busy = (rs1_sel != '0) && rs1_hit;
   assign rs2_busy = (rs2_sel != '0) && rs2_hit;

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a vector table for single-cycle behaviour plus
// hand-written sequences for streaming with pointer wrap and asynchronous reset.
module tb_wb_queue;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_sel;
   logic [31:0] in_data;
   logic        drain_en;
   logic        wEn;
   logic [4:0]  write_sel;
   logic [31:0] write_data;
   logic [4:0]  rs1_sel;
   logic [4:0]  rs2_sel;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int checks = 0;
   int errors = 0;

   wb_queue #(.DEPTH(4), .DATA_W(32), .SEL_W(5)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .drain_en   (drain_en),
      .wEn        (wEn),
      .write_sel  (write_sel),
      .write_data (write_data),
      .rs1_sel    (rs1_sel),
      .rs2_sel    (rs2_sel),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .count      (count),
      .full       (full),
      .empty      (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        iv;
      logic [4:0]  isel;
      logic [31:0] idata;
      logic        de;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        e_wen;
      logic [4:0]  e_sel;
      logic [31:0] e_data;
      logic [2:0]  e_count;
      logic        e_ready;
      logic        e_b1;
      logic        e_b2;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(input logic iv, input logic [4:0] isel, input logic [31:0] idata,
                               input logic de, input logic [4:0] r1, input logic [4:0] r2,
                               input logic e_wen, input logic [4:0] e_sel, input logic [31:0] e_data,
                               input logic [2:0] e_count, input logic e_ready,
                               input logic e_b1, input logic e_b2);
      vec_t v;
      v.iv = iv; v.isel = isel; v.idata = idata; v.de = de; v.r1 = r1; v.r2 = r2;
      v.e_wen = e_wen; v.e_sel = e_sel; v.e_data = e_data; v.e_count = e_count;
      v.e_ready = e_ready; v.e_b1 = e_b1; v.e_b2 = e_b2;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [4:0] isel, input logic [31:0] idata,
                        input logic de);
      in_valid = iv;
      in_sel   = isel;
      in_data  = idata;
      drain_en = de;
   endtask

   task automatic check_outputs(input string tag, input logic e_wen, input logic [4:0] e_sel,
                                input logic [31:0] e_data, input logic [2:0] e_count);
      check({tag, " wEn"},        64'(wEn),        64'(e_wen));
      check({tag, " write_sel"},  64'(write_sel),  64'(e_sel));
      check({tag, " write_data"}, 64'(write_data), 64'(e_data));
      check({tag, " count"},      64'(count),      64'(e_count));
   endtask

   initial begin
      vecs[0]  = mk(1, 3, 32'hDEADBEEF, 1, 3, 0,  0, 0, 32'h0,        1, 1, 1, 0);
      vecs[1]  = mk(0, 0, 32'h0,        1, 3, 0,  1, 3, 32'hDEADBEEF, 0, 1, 1, 0);
      vecs[2]  = mk(0, 0, 32'h0,        1, 3, 0,  0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
      vecs[3]  = mk(1, 0, 32'h1234,     1, 0, 3,  0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
      vecs[4]  = mk(0, 0, 32'h0,        1, 0, 3,  0, 3, 32'hDEADBEEF, 0, 1, 0, 0);
      vecs[5]  = mk(1, 5, 32'hA,        1, 0, 5,  0, 3, 32'hDEADBEEF, 1, 1, 0, 1);
      vecs[6]  = mk(1, 5, 32'hB,        1, 0, 5,  1, 5, 32'hA,        1, 1, 0, 1);
      vecs[7]  = mk(0, 0, 32'h0,        1, 0, 5,  1, 5, 32'hB,        0, 1, 0, 1);
      vecs[8]  = mk(0, 0, 32'h0,        1, 0, 5,  0, 5, 32'hB,        0, 1, 0, 0);
      vecs[9]  = mk(1, 1, 32'h11,       0, 4, 1,  0, 5, 32'hB,        1, 1, 0, 1);
      vecs[10] = mk(1, 2, 32'h22,       0, 4, 1,  0, 5, 32'hB,        2, 1, 0, 1);
      vecs[11] = mk(1, 3, 32'h33,       0, 4, 1,  0, 5, 32'hB,        3, 1, 0, 1);
      vecs[12] = mk(1, 4, 32'h44,       0, 4, 1,  0, 5, 32'hB,        4, 0, 1, 1);
      vecs[13] = mk(1, 6, 32'h66,       0, 6, 1,  0, 5, 32'hB,        4, 0, 0, 1);
      vecs[14] = mk(1, 7, 32'h77,       1, 7, 1,  1, 1, 32'h11,       3, 1, 0, 1);
      vecs[15] = mk(0, 0, 32'h0,        1, 4, 1,  1, 2, 32'h22,       2, 1, 1, 0);
      vecs[16] = mk(0, 0, 32'h0,        1, 4, 1,  1, 3, 32'h33,       1, 1, 1, 0);
      vecs[17] = mk(0, 0, 32'h0,        1, 4, 1,  1, 4, 32'h44,       0, 1, 1, 0);
      vecs[18] = mk(0, 0, 32'h0,        1, 4, 1,  0, 4, 32'h44,       0, 1, 0, 0);

      reset = 1'b0;
      drive(0, 0, 0, 0);
      rs1_sel = '0;
      rs2_sel = '0;
      #12;
      check_outputs("reset", 0, 0, 0, 0);
      check("reset empty",    64'(empty),    64'd1);
      check("reset full",     64'(full),     64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      @(negedge clock);
      reset = 1'b1;

      // Single write, register zero, same-register ordering, fill and back-pressure.
      for (int i = 0; i < 19; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         @(negedge clock);
         drive(vecs[i].iv, vecs[i].isel, vecs[i].idata, vecs[i].de);
         rs1_sel = vecs[i].r1;
         rs2_sel = vecs[i].r2;
         @(posedge clock);
         #1;
         check_outputs(tag, vecs[i].e_wen, vecs[i].e_sel, vecs[i].e_data, vecs[i].e_count);
         check({tag, " in_ready"}, 64'(in_ready), 64'(vecs[i].e_ready));
         check({tag, " full"},     64'(full),     64'(vecs[i].e_count == 3'd4));
         check({tag, " empty"},    64'(empty),    64'(vecs[i].e_count == 3'd0));
         check({tag, " rs1_busy"}, 64'(rs1_busy), 64'(vecs[i].e_b1));
         check({tag, " rs2_busy"}, 64'(rs2_busy), 64'(vecs[i].e_b2));
      end

      // Stream at occupancy DEPTH-1: prime sels 10..12, then push 13..22 while draining.
      rs1_sel = '0;
      rs2_sel = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         drive(1, 5'(10 + k), 32'(10 + k) * 32'h01010101, 0);
      end
      @(posedge clock);
      #1;
      check("prime count", 64'(count), 64'd3);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         drive(1, 5'(13 + k), 32'(13 + k) * 32'h01010101, 1);
         @(posedge clock);
         #1;
         check_outputs($sformatf("stream%0d", k), 1, 5'(10 + k), 32'(10 + k) * 32'h01010101, 3);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         drive(0, 0, 0, 1);
         @(posedge clock);
         #1;
         check_outputs($sformatf("tail%0d", k), 1, 5'(20 + k), 32'(20 + k) * 32'h01010101,
                       3'(2 - k));
      end
      @(negedge clock);
      @(posedge clock);
      #1;
      check("stream done wEn", 64'(wEn),   64'd0);
      check("stream empty",    64'(empty), 64'd1);

      // Asynchronous reset while draining with a write in flight.
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         drive(1, 5'(7 + k), 32'(7 + k), 0);
      end
      @(negedge clock);
      drive(0, 0, 0, 1);
      rs1_sel = 5'd8;
      @(posedge clock);
      #1;
      check_outputs("pre-reset", 1, 7, 32'd7, 2);
      #2;
      reset = 1'b0;
      #1;
      check_outputs("async reset", 0, 0, 0, 0);
      check("async reset empty",    64'(empty),    64'd1);
      check("async reset in_ready", 64'(in_ready), 64'd1);
      check("async reset rs1_busy", 64'(rs1_busy), 64'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clock);
         #1;
         check_outputs($sformatf("post-reset%0d", k), 0, 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
